// File: rtl/data_memory_ctrl_if.sv
// Request/response bus for data_memory_ctrl: one request per cycle, one
// registered response pulse per accepted request.
interface data_memory_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                      req_i;
    logic                      we_i;
    logic [ADDR_WIDTH-1:0]     addr_i;
    logic [DATA_WIDTH-1:0]     wdata_i;
    logic [DATA_WIDTH/8-1:0]   be_i;
    logic                      ready_o;
    logic                      rvalid_o;
    logic [DATA_WIDTH-1:0]     rdata_o;
    logic                      err_o;
    logic                      busy_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  ready_o, rvalid_o, rdata_o, err_o, busy_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output ready_o, rvalid_o, rdata_o, err_o, busy_o
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Word-organised data memory with byte-lane writes, latency-1 reads,
// illegal-access error responses and a self-clear sequence after reset.
module data_memory_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    data_memory_ctrl_if.slave     bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEMORY_DEPTH);

    localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(MEMORY_DEPTH - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]            state;
    logic [IDX_W-1:0]      clr_cnt;
    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    logic                  rvalid_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [ADDR_WIDTH-1:0] word_addr;
    logic [IDX_W-1:0]      word_idx;
    logic                  aligned;
    logic                  in_range;
    logic                  legal;
    logic                  accept;
    logic                  wr_acc;
    logic                  rd_acc;

    // Address decode: legality is judged on the full address before the
    // index is truncated, so out-of-range addresses never alias low words.
    always_comb begin
        word_addr = bus.addr_i >> OFFS;
        word_idx  = word_addr[IDX_W-1:0];
        aligned   = (bus.addr_i & OFFS_MASK) == '0;
        in_range  = (word_addr >> IDX_W) == '0;
        legal     = aligned && in_range;
        accept    = (state == ST_IDLE) && bus.req_i && !reset;
        wr_acc    = accept && legal && bus.we_i;
        rd_acc    = accept && legal && !bus.we_i;
    end

    // Clear sequencer: walk every word once, then open the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + IDX_W'(1);
            if (clr_cnt == LAST_IDX) begin
                state <= ST_IDLE;
            end
        end
    end

    // Storage: zero one word per clear cycle, otherwise apply byte-lane writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (wr_acc) begin
                for (int unsigned k = 0; k < BYTES; k++) begin
                    if (bus.be_i[k]) begin
                        mem[word_idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
                    end
                end
            end
        end
    end

    // Response register: one pulse per accepted request, data only for legal reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= accept;
            err_q    <= accept && !legal;
            rdata_q  <= rd_acc ? mem[word_idx] : '0;
        end
    end

    assign bus.ready_o  = (state == ST_IDLE);
    assign bus.busy_o   = (state == ST_CLEAR);
    assign bus.rvalid_o = rvalid_q;
    assign bus.err_o    = err_q;
    assign bus.rdata_o  = rdata_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl (32-bit words, 64-word depth).
module tb_data_memory_ctrl;
    logic clk;
    logic reset;

    int errors;
    int checks;

    data_memory_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    data_memory_ctrl #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .MEMORY_DEPTH(64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one request for one cycle; outputs are sampled 1 time unit after the edge.
    task automatic issue(input logic rq, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        bus.req_i   = rq;
        bus.we_i    = we;
        bus.addr_i  = addr;
        bus.wdata_i = wdata;
        bus.be_i    = be;
        @(posedge clk);
        #1;
    endtask

    task automatic check_resp(input string name, input logic err, input logic [31:0] rdata);
        check({name, ".rvalid"}, 32'(bus.rvalid_o), 32'd1);
        check({name, ".err"},    32'(bus.err_o),    32'(err));
        check({name, ".rdata"},  bus.rdata_o,       rdata);
    endtask

    // Release reset and count clear cycles; a read request is held throughout
    // and must never be answered.
    task automatic release_and_count(input string name);
        int  n;
        logic stray;
        n = 0;
        stray = 1'b0;
        reset = 1'b0;
        bus.req_i = 1'b1;
        bus.we_i  = 1'b0;
        bus.addr_i = 32'h0;
        while (bus.busy_o && n < 200) begin
            if (bus.ready_o) stray = 1'b1;
            @(posedge clk);
            #1;
            n++;
            if (bus.rvalid_o) stray = 1'b1;
        end
        bus.req_i = 1'b0;
        check({name, ".busy_cycles"}, 32'(n), 32'd64);
        check({name, ".ready_after"}, 32'(bus.ready_o), 32'd1);
        check({name, ".no_resp_in_clear"}, 32'(stray), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".ready"},  32'(bus.ready_o),  32'd0);
        check({name, ".busy"},   32'(bus.busy_o),   32'd1);
        check({name, ".rvalid"}, 32'(bus.rvalid_o), 32'd0);
        check({name, ".err"},    32'(bus.err_o),    32'd0);
        check({name, ".rdata"},  bus.rdata_o,       32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        bus.req_i = 1'b0;
        bus.we_i = 1'b0;
        bus.addr_i = '0;
        bus.wdata_i = '0;
        bus.be_i = '0;

        //             we    addr          wdata         be     err   rdata
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,          4'hF, 1'b0, 32'h0000_0000});
        vecs.push_back('{1'b1, 32'h0000_0000, 32'hFFFF_FFFF,  4'hF, 1'b0, 32'h0000_0000});
        vecs.push_back('{1'b1, 32'h0000_0008, 32'h1234_5678,  4'hF, 1'b0, 32'h0000_0000});
        vecs.push_back('{1'b0, 32'h0000_0008, 32'h0,          4'h0, 1'b0, 32'h1234_5678});
        vecs.push_back('{1'b1, 32'h0000_0010, 32'h9876_1234,  4'hF, 1'b0, 32'h0000_0000});
        vecs.push_back('{1'b1, 32'h0000_0010, 32'hA0A0_A0A0,  4'h5, 1'b0, 32'h0000_0000});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,          4'h0, 1'b0, 32'h98A0_12A0});
        vecs.push_back('{1'b0, 32'h0000_0002, 32'h0,          4'h0, 1'b1, 32'h0000_0000});
        vecs.push_back('{1'b0, 32'h0000_0100, 32'h0,          4'h0, 1'b1, 32'h0000_0000});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,          4'h0, 1'b0, 32'hFFFF_FFFF});
        vecs.push_back('{1'b1, 32'h0000_0004, 32'h5555_5555,  4'h0, 1'b0, 32'h0000_0000});
        vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,          4'h0, 1'b0, 32'h0000_0000});
        vecs.push_back('{1'b1, 32'h0000_00FC, 32'hDEAD_BEEF,  4'hF, 1'b0, 32'h0000_0000});
        vecs.push_back('{1'b0, 32'h0000_00FC, 32'h0,          4'h0, 1'b0, 32'hDEAD_BEEF});
        vecs.push_back('{1'b1, 32'h0000_0001, 32'h1111_1111,  4'hF, 1'b1, 32'h0000_0000});
        vecs.push_back('{1'b1, 32'h0000_0104, 32'hCAFE_F00D,  4'hF, 1'b1, 32'h0000_0000});
        vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,          4'h0, 1'b0, 32'h0000_0000});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,          4'h0, 1'b0, 32'hFFFF_FFFF});

        // Reset state and first clear sequence.
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        release_and_count("clear1");

        // Table: back-to-back requests, one per cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            issue(1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            check_resp($sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_rdata);
        end

        // Idle cycle: no response, rdata held at zero.
        issue(1'b0, 1'b0, 32'h8, 32'h0, 4'h0);
        check("idle.rvalid", 32'(bus.rvalid_o), 32'd0);
        check("idle.rdata", bus.rdata_o, 32'd0);

        // Alternating write/read over 16 addresses at full rate.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] pat;
            pat = 32'hC000_0000 | (32'(i) << 8) | 32'(i * 3);
            issue(1'b1, 1'b1, 32'(i * 4), pat, 4'hF);
            check_resp($sformatf("alt_wr%0d", i), 1'b0, 32'h0);
            issue(1'b1, 1'b0, 32'(i * 4), 32'h0, 4'h0);
            check_resp($sformatf("alt_rd%0d", i), 1'b0, pat);
        end

        // Write a word, then reset mid-clear and confirm it was wiped.
        issue(1'b1, 1'b1, 32'h14, 32'hABCD_EF12, 4'hF);
        check_resp("pre.wr", 1'b0, 32'h0);
        issue(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
        check_resp("pre.rd", 1'b0, 32'hABCD_EF12);

        // Request coincident with reset: not accepted, pending response dropped.
        reset = 1'b1;
        issue(1'b1, 1'b1, 32'h18, 32'h7777_7777, 4'hF);
        check_reset_outputs("reset2");
        reset = 1'b0;
        bus.req_i = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
        end
        check("mid_clear.busy", 32'(bus.busy_o), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("reset3");
        release_and_count("clear2");

        issue(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
        check_resp("post.rd14", 1'b0, 32'h0);
        issue(1'b1, 1'b0, 32'h18, 32'h0, 4'h0);
        check_resp("post.rd18", 1'b0, 32'h0);
        issue(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter ADDR_WIDTH, default 32: byte-address width.
REQ-003 Parameter MEMORY_DEPTH, default 64: number of words; SHALL be a power of two, minimum 2.
REQ-004 Derived: BYTES = DATA_WIDTH/8; OFFS = log2(BYTES); word index = addr_i >> OFFS.
REQ-005 Port: clk  input  1  single clock; all logic on rising edge.
REQ-006 Port: reset  input  1  synchronous, active-high reset.
REQ-007 Port: req_i  input  1  access request.
REQ-008 Port: we_i  input  1  1 = write, 0 = read; sampled with req_i.
REQ-009 Port: addr_i  input  ADDR_WIDTH  byte address.
REQ-010 Port: wdata_i  input  DATA_WIDTH  write data.
REQ-011 Port: be_i  input  BYTES  byte-lane write enables; bit k covers wdata_i[8k+7:8k].
REQ-012 Port: ready_o  output  1  block can accept a request this cycle.
REQ-013 Port: rvalid_o  output  1  one-cycle pulse: response for the previously accepted request.
REQ-014 Port: rdata_o  output  DATA_WIDTH  read data; valid only while rvalid_o = 1.
REQ-015 Port: err_o  output  1  one-cycle pulse with rvalid_o: previously accepted request was illegal.
REQ-016 Port: busy_o  output  1  memory clear in progress.

Function
REQ-017 Two states: CLEAR and IDLE.
REQ-018 CLEAR: clear counter starts at 0, one word zeroed per cycle; counter increments by 1 each cycle.
REQ-019 CLEAR -> IDLE on the cycle the word at MEMORY_DEPTH-1 is zeroed; CLEAR lasts exactly MEMORY_DEPTH cycles.
REQ-020 In CLEAR: ready_o = 0, busy_o = 1; req_i ignored, no response generated.
REQ-021 In IDLE: ready_o = 1, busy_o = 0; request accepted on any cycle with req_i = 1.
REQ-022 Request illegal if addr_i[OFFS-1:0] != 0 (misaligned) or word index >= MEMORY_DEPTH (out of range).
REQ-023 Accepted legal write: each byte lane with be_i[k] = 1 updated at that edge; lanes with be_i[k] = 0 unchanged; be_i = 0 writes nothing.
REQ-024 Accepted legal read: stored word returned in rdata_o one cycle later (latency 1).
REQ-025 Every accepted request, read or write, produces exactly one rvalid_o pulse in the following cycle; for writes, rdata_o = 0.
REQ-026 Accepted illegal request: no memory change, next cycle rvalid_o = 1, err_o = 1, rdata_o = 0.
REQ-027 Back-to-back requests on consecutive cycles SHALL be accepted at full throughput, one response per cycle.
REQ-028 Read in the cycle immediately after a write to the same address SHALL return the newly written data.
REQ-029 rdata_o SHALL hold 0 whenever rvalid_o = 0.
REQ-030 Word index SHALL use only its low log2(MEMORY_DEPTH) bits after the range check; no wrap-around aliasing of illegal addresses.

Reset
REQ-031 reset = 1 at a rising edge SHALL: enter CLEAR, clear counter = 0, ready_o = 0, busy_o = 1, rvalid_o = 0, err_o = 0, rdata_o = 0.
REQ-032 Reset during CLEAR restarts clearing from word 0; reset in IDLE discards any pending response (no rvalid_o after reset).
REQ-033 A request present in the same cycle as reset SHALL NOT be accepted or written.
REQ-034 After reset release, all words read as 0 once ready_o = 1.

Verification
REQ-035 Reset then release, DEPTH=64 -> busy_o high exactly 64 cycles, ready_o rises on 65th; read addr 0x0 -> rdata_o = 0x00000000, err_o = 0.
REQ-036 Write 0xFFFFFFFF to 0x0 (be=4'hF), write 0x12345678 to 0x8, read 0x8 next cycle -> rdata_o = 0x12345678 one cycle after read accept.
REQ-037 Word 0x10 = 0x98761234; write 0xA0A0A0A0 with be=4'b0101; read -> 0x98A012A0.
REQ-038 Read addr 0x2 (misaligned) and addr 0x100 (index 64, out of range) -> rvalid_o = 1, err_o = 1, rdata_o = 0; subsequent read of 0x0 unchanged.
REQ-039 Assert reset at clear count 30 -> clear restarts; busy_o high 64 further cycles; previously written 0xABCDEF12 at 0x14 reads 0 afterwards.
REQ-040 Alternating write/read every cycle over 16 addresses -> 16 responses, no lost cycles, every read matches the last written value.
